// File: rtl/pipe_redirect_ctrl_pkg.sv
// Shared pipeline definitions for the PC-redirect / hazard sequencer.
//   JOP_*          : jump opcode encoding resolved in EX
//   state_t        : sequencer state encoding
//   is_load_use()  : ID-stage load-use compare against the load sitting in EX
package pipe_redirect_ctrl_pkg;

    localparam logic [1:0] JOP_SEQ = 2'b00;
    localparam logic [1:0] JOP_BR  = 2'b01;
    localparam logic [1:0] JOP_JR  = 2'b10;
    localparam logic [1:0] JOP_J   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_SQUASH   = 2'd2
    } state_t;

    // Register 0 is hardwired, so a load into it never creates a dependency.
    function automatic logic is_load_use(input logic       memread,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt);
        return memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    endfunction

endpackage

// File: rtl/pipe_redirect_ctrl_if.sv
// Pipeline-side bundle of the redirect/hazard sequencer.
//   master : pipeline datapath (drives EX/ID status, consumes controls and counters)
//   slave  : the sequencer
// Signals:
//   ex_valid, jump_op[1:0], id_ex_memread, id_ex_rt[4:0], if_id_rs[4:0], if_id_rt[4:0]
//   pc_sel[1:0], pc_write, if_id_write, if_id_flush, id_ex_flush,
//   stall_cnt[CNT_W-1:0], redir_cnt[CNT_W-1:0]
interface pipe_redirect_ctrl_if #(parameter int CNT_W = 16);

    logic             ex_valid;
    logic [1:0]       jump_op;
    logic             id_ex_memread;
    logic [4:0]       id_ex_rt;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;

    logic [1:0]       pc_sel;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redir_cnt;

    modport master (
        output ex_valid, jump_op, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
        input  pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush,
               stall_cnt, redir_cnt
    );

    modport slave (
        input  ex_valid, jump_op, id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
        output pc_sel, pc_write, if_id_write, if_id_flush, id_ex_flush,
               stall_cnt, redir_cnt
    );

endinterface

// File: rtl/pipe_redirect_ctrl_sat_counter.sv
// Saturating event counter: counts clock cycles with inc high, sticks at all-ones.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset (clears count)
//   inc : count enable for this cycle
//   cnt : current count, W bits
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_redirect_ctrl.sv
// PC-redirect and load-use hazard sequencer for the 5-stage pipeline.
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : pipe_redirect_ctrl_if.slave (EX/ID status in, PC/IF-ID/ID-EX controls
//         and stall/redirect counters out)
// Controls are combinational from state and inputs (same-cycle response).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; accepts redirects and load-use stalls
// ST_LU_STALL | one bubble already inserted; behaves as RUN, may stall again
// ST_SQUASH   | wrong-path shadow after a redirect; requests ignored
module pipe_redirect_ctrl
    import pipe_redirect_ctrl_pkg::*;
#(
    parameter int SQUASH_CYC = 2,
    parameter int CNT_W      = 16
) (
    input logic                clk,
    input logic                rst,
    pipe_redirect_ctrl_if.slave bus
);

    localparam int               SQ_W    = $clog2(SQUASH_CYC) + 1;
    localparam logic [SQ_W-1:0]  SQ_INIT = SQ_W'(SQUASH_CYC - 1);

    state_t          state;
    logic [SQ_W-1:0] sq_cnt;
    logic            redirect_req;
    logic            lu_hit;
    logic            stall_evt;

    assign redirect_req = bus.ex_valid && (bus.jump_op != JOP_SEQ) && (state != ST_SQUASH);
    assign lu_hit       = is_load_use(bus.id_ex_memread, bus.id_ex_rt, bus.if_id_rs, bus.if_id_rt);
    // Redirect wins over load-use: the stalled instruction is on the wrong path anyway.
    assign stall_evt    = lu_hit && !redirect_req && (state != ST_SQUASH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_RUN;
            sq_cnt <= '0;
        end else begin
            case (state)
                ST_RUN, ST_LU_STALL: begin
                    if (redirect_req) begin
                        state  <= ST_SQUASH;
                        sq_cnt <= SQ_INIT;
                    end else if (lu_hit) begin
                        state <= ST_LU_STALL;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        sq_cnt <= sq_cnt - SQ_W'(1);
                    end
                end
                default: begin
                    state  <= ST_RUN;
                    sq_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.pc_sel      = JOP_SEQ;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        if (!rst) begin
            // Hold the front end frozen and both pipeline registers cleared.
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (redirect_req) begin
            bus.pc_sel      = bus.jump_op;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (stall_evt) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_evt),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk (clk),
        .rst (rst),
        .inc (redirect_req),
        .cnt (bus.redir_cnt)
    );

endmodule
